// File: rtl/baccarat_pkg.sv
// Shared card codes, seven-segment patterns and scoring helpers for the Baccarat datapath.
// Seven-segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package baccarat_pkg;

    localparam logic [3:0] CARD_NONE  = 4'd0;
    localparam logic [3:0] CARD_ACE   = 4'd1;
    localparam logic [3:0] CARD_NINE  = 4'd9;
    localparam logic [3:0] CARD_TEN   = 4'd10;
    localparam logic [3:0] CARD_JACK  = 4'd11;
    localparam logic [3:0] CARD_QUEEN = 4'd12;
    localparam logic [3:0] CARD_KING  = 4'd13;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ACE   = 7'b0001000;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_TEN   = 7'b1000000;
    localparam logic [6:0] SEG_JACK  = 7'b1100001;
    localparam logic [6:0] SEG_QUEEN = 7'b0011000;
    localparam logic [6:0] SEG_KING  = 7'b0001001;

    // Face cards, tens, empty slots and illegal codes all count as zero.
    function automatic logic [3:0] card_value(input logic [3:0] card);
        if (card >= CARD_ACE && card <= CARD_NINE)
            return card;
        return CARD_NONE;
    endfunction

    // Sum is at most 27, so two conditional subtractions replace a divider.
    function automatic logic [3:0] hand_score(input logic [3:0] c1,
                                              input logic [3:0] c2,
                                              input logic [3:0] c3);
        logic [4:0] sum;
        sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
        if (sum >= 5'd20)
            sum = sum - 5'd20;
        else if (sum >= 5'd10)
            sum = sum - 5'd10;
        return sum[3:0];
    endfunction

    function automatic logic [6:0] card_to_seg(input logic [3:0] card);
        logic [6:0] seg;
        case (card)
            CARD_NONE:  seg = SEG_BLANK;
            CARD_ACE:   seg = SEG_ACE;
            4'd2:       seg = SEG_2;
            4'd3:       seg = SEG_3;
            4'd4:       seg = SEG_4;
            4'd5:       seg = SEG_5;
            4'd6:       seg = SEG_6;
            4'd7:       seg = SEG_7;
            4'd8:       seg = SEG_8;
            CARD_NINE:  seg = SEG_9;
            CARD_TEN:   seg = SEG_TEN;
            CARD_JACK:  seg = SEG_JACK;
            CARD_QUEEN: seg = SEG_QUEEN;
            CARD_KING:  seg = SEG_KING;
            default:    seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/baccarat_datapath_dealcard.sv
// Free-running card generator: cycles Ace..King (1..13), one step per clock.
module dealcard
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    output logic [3:0] dealer_card
);

    logic [3:0] r_count_p0;

    always_ff @(posedge slow_clock) begin
        if (resetb)
            r_count_p0 <= CARD_ACE;
        else if (r_count_p0 == CARD_KING)
            r_count_p0 <= CARD_ACE;
        else
            r_count_p0 <= r_count_p0 + 4'd1;
    end

    // Kept as a plain continuous assign so a bench can force and release the port.
    assign dealer_card = r_count_p0;

endmodule

// File: rtl/baccarat_datapath.sv
// Baccarat card-holding and scoring datapath: six card slots, mod-10 scores, 7-seg decode.
// Define BACCARAT_REG_OUTPUTS_EN to register scores and HEX outputs (one extra cycle).
module baccarat_datapath
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard3_out,
    output logic [3:0] pscore_out,
    output logic [3:0] dscore_out,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    logic [3:0] w_dealer_card;
    logic [5:0] w_load;
    logic [3:0] r_card_p0 [6];
    logic [3:0] w_pscore;
    logic [3:0] w_dscore;
    logic [6:0] w_seg [6];
    logic [6:0] w_hex [6];

    dealcard DC (
        .slow_clock  (slow_clock),
        .resetb      (resetb),
        .dealer_card (w_dealer_card)
    );

    // Slots 0..2 are player cards 1..3, slots 3..5 are dealer cards 1..3.
    assign w_load = {load_dcard3, load_dcard2, load_dcard1,
                     load_pcard3, load_pcard2, load_pcard1};

    // ---- stage p0: card registers ----
    always_ff @(posedge slow_clock) begin
        for (int i = 0; i < 6; i++) begin
            if (resetb)
                r_card_p0[i] <= CARD_NONE;
            else if (w_load[i])
                r_card_p0[i] <= w_dealer_card;
        end
    end

    assign w_pscore = hand_score(r_card_p0[0], r_card_p0[1], r_card_p0[2]);
    assign w_dscore = hand_score(r_card_p0[3], r_card_p0[4], r_card_p0[5]);

    for (genvar g = 0; g < 6; g++) begin : g_seg
        assign w_seg[g] = card_to_seg(r_card_p0[g]);
    end

`ifdef BACCARAT_REG_OUTPUTS_EN
    // ---- stage p1: optional output registers ----
    logic [3:0] r_pscore_p1;
    logic [3:0] r_dscore_p1;
    logic [6:0] r_seg_p1 [6];

    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            r_pscore_p1 <= 4'd0;
            r_dscore_p1 <= 4'd0;
            for (int i = 0; i < 6; i++)
                r_seg_p1[i] <= SEG_BLANK;
        end else begin
            r_pscore_p1 <= w_pscore;
            r_dscore_p1 <= w_dscore;
            for (int i = 0; i < 6; i++)
                r_seg_p1[i] <= w_seg[i];
        end
    end

    assign pscore_out = r_pscore_p1;
    assign dscore_out = r_dscore_p1;
    for (genvar g = 0; g < 6; g++) begin : g_hex_reg
        assign w_hex[g] = r_seg_p1[g];
    end
`else
    assign pscore_out = w_pscore;
    assign dscore_out = w_dscore;
    for (genvar g = 0; g < 6; g++) begin : g_hex_comb
        assign w_hex[g] = w_seg[g];
    end
`endif

    assign pcard3_out = r_card_p0[2];

    assign HEX0 = w_hex[0];
    assign HEX1 = w_hex[1];
    assign HEX2 = w_hex[2];
    assign HEX3 = w_hex[3];
    assign HEX4 = w_hex[4];
    assign HEX5 = w_hex[5];

endmodule

// File: tb/tb_baccarat_datapath.sv
// Self-checking bench for baccarat_datapath: directed hand scenarios plus random loads/resets
// compared every cycle against a card-level model of the game datapath.
`timescale 1ns/1ps
module tb_baccarat_datapath;

    logic       slow_clock = 1'b0;
    logic       resetb = 1'b1;
    logic       load_pcard1 = 1'b0, load_pcard2 = 1'b0, load_pcard3 = 1'b0;
    logic       load_dcard1 = 1'b0, load_dcard2 = 1'b0, load_dcard3 = 1'b0;
    logic [3:0] pcard3_out, pscore_out, dscore_out;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int checks = 0;
    int errors = 0;

    baccarat_datapath dut (
        .slow_clock  (slow_clock),
        .resetb      (resetb),
        .load_pcard1 (load_pcard1),
        .load_pcard2 (load_pcard2),
        .load_pcard3 (load_pcard3),
        .load_dcard1 (load_dcard1),
        .load_dcard2 (load_dcard2),
        .load_dcard3 (load_dcard3),
        .pcard3_out  (pcard3_out),
        .pscore_out  (pscore_out),
        .dscore_out  (dscore_out),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX2        (HEX2),
        .HEX3        (HEX3),
        .HEX4        (HEX4),
        .HEX5        (HEX5)
    );

    always #5 slow_clock = ~slow_clock;

`ifdef BACCARAT_REG_OUTPUTS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    localparam logic [6:0] BLANK = 7'b1111111;

    // Display table indexed by card code.
    logic [6:0] seg_tab [16] = '{7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001,
                                 7'b0011000, 7'b0001001, 7'b1111111, 7'b1111111};

    int         m_card [6];
    int         m_gen = 1;
    int         m_ovr = -1;
    bit         chk_en = 1'b0;
    int         e_ps = 0, e_ds = 0, e_p3 = 0;
    logic [6:0] e_hex [6];
    logic [3:0] f_card = 4'd0;

    function automatic int val(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on every rising edge.
    initial begin
        int         cur;
        int         pre_ps, pre_ds;
        logic [6:0] pre_hex [6];
        logic [5:0] ld;
        for (int i = 0; i < 6; i++) begin
            m_card[i] = 0;
            e_hex[i] = BLANK;
        end
        forever begin
            @(posedge slow_clock);
            ld = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};
            cur = (m_ovr >= 0) ? m_ovr : m_gen;
            pre_ps = (val(m_card[0]) + val(m_card[1]) + val(m_card[2])) % 10;
            pre_ds = (val(m_card[3]) + val(m_card[4]) + val(m_card[5])) % 10;
            for (int i = 0; i < 6; i++) pre_hex[i] = seg_tab[m_card[i]];
            if (resetb) begin
                for (int i = 0; i < 6; i++) m_card[i] = 0;
                m_gen = 1;
            end else begin
                for (int i = 0; i < 6; i++) if (ld[i]) m_card[i] = cur;
                m_gen = (m_gen % 13) + 1;
            end
            e_p3 = m_card[2];
            if (LAT == 0) begin
                e_ps = (val(m_card[0]) + val(m_card[1]) + val(m_card[2])) % 10;
                e_ds = (val(m_card[3]) + val(m_card[4]) + val(m_card[5])) % 10;
                for (int i = 0; i < 6; i++) e_hex[i] = seg_tab[m_card[i]];
            end else if (resetb) begin
                e_ps = 0;
                e_ds = 0;
                for (int i = 0; i < 6; i++) e_hex[i] = BLANK;
            end else begin
                e_ps = pre_ps;
                e_ds = pre_ds;
                for (int i = 0; i < 6; i++) e_hex[i] = pre_hex[i];
            end
        end
    end

    // Cycle compare against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge slow_clock);
            if (chk_en) begin
                check("pscore", pscore_out, e_ps);
                check("dscore", dscore_out, e_ds);
                check("pcard3", pcard3_out, e_p3);
                check("hex0", HEX0, e_hex[0]);
                check("hex1", HEX1, e_hex[1]);
                check("hex2", HEX2, e_hex[2]);
                check("hex3", HEX3, e_hex[3]);
                check("hex4", HEX4, e_hex[4]);
                check("hex5", HEX5, e_hex[5]);
            end
        end
    end

    // Called at a falling edge; loads the given card into every slot in mask for one cycle.
    task automatic load(input logic [5:0] mask, input logic [3:0] card);
        f_card = card;
        force dut.DC.dealer_card = f_card;
        m_ovr = card;
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = mask;
        @(posedge slow_clock);
        @(negedge slow_clock);
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = 6'b0;
        release dut.DC.dealer_card;
        m_ovr = -1;
        repeat (LAT) begin
            @(posedge slow_clock);
            @(negedge slow_clock);
        end
    endtask

    task automatic pulse_reset();
        resetb = 1'b1;
        @(posedge slow_clock);
        @(negedge slow_clock);
        resetb = 1'b0;
    endtask

    initial begin
        resetb = 1'b1;
        repeat (2) @(posedge slow_clock);
        @(negedge slow_clock);
        chk_en = 1'b1;
        check("rst_pscore", pscore_out, 0);
        check("rst_dscore", dscore_out, 0);
        check("rst_pcard3", pcard3_out, 0);
        check("rst_hex0", HEX0, BLANK);
        check("rst_hex5", HEX5, BLANK);
        resetb = 1'b0;

        // Hand progression.
        load(6'b000001, 4'd2);
        check("h1_pscore", pscore_out, 2);
        check("h1_dscore", dscore_out, 0);
        check("h1_hex0", HEX0, 7'b0100100);
        check("h1_hex1", HEX1, BLANK);
        check("h1_hex3", HEX3, BLANK);
        load(6'b001000, 4'd11);
        check("h2_hex3", HEX3, 7'b1100001);
        check("h2_dscore", dscore_out, 0);
        load(6'b000010, 4'd8);
        check("h3_pscore", pscore_out, 0);
        check("h3_hex1", HEX1, 7'b0000000);
        load(6'b010000, 4'd12);
        check("h4_hex4", HEX4, 7'b0011000);
        check("h4_dscore", dscore_out, 0);
        load(6'b000100, 4'd3);
        check("h5_pscore", pscore_out, 3);
        check("h5_pcard3", pcard3_out, 3);
        check("h5_hex2", HEX2, 7'b0110000);
        load(6'b100000, 4'd4);
        check("h6_dscore", dscore_out, 4);
        check("h6_hex5", HEX5, 7'b0011001);

        // Reset after a full hand.
        pulse_reset();
        check("hr_pscore", pscore_out, 0);
        check("hr_dscore", dscore_out, 0);
        check("hr_hex0", HEX0, BLANK);
        check("hr_hex2", HEX2, BLANK);
        check("hr_hex4", HEX4, BLANK);
        check("hr_hex5", HEX5, BLANK);

        // Modulo wrap.
        load(6'b000001, 4'd9);
        load(6'b000010, 4'd9);
        load(6'b000100, 4'd9);
        check("mod_999", pscore_out, 7);
        load(6'b000001, 4'd13);
        load(6'b000010, 4'd10);
        load(6'b000100, 4'd1);
        check("mod_kta", pscore_out, 1);
        check("mod_hex0", HEX0, 7'b0001001);

        // Simultaneous loads.
        pulse_reset();
        load(6'b001001, 4'd5);
        check("sim_hex0", HEX0, 7'b0010010);
        check("sim_hex3", HEX3, 7'b0010010);
        check("sim_pscore", pscore_out, 5);
        check("sim_dscore", dscore_out, 5);

        // Reset wins over a same-cycle load.
        resetb = 1'b1;
        load(6'b000001, 4'd7);
        resetb = 1'b0;
        check("rl_pscore", pscore_out, 0);
        check("rl_hex0", HEX0, BLANK);

        // Generator sequence after reset.
        pulse_reset();
        for (int i = 0; i < 14; i++) begin
            check("gen_seq", dut.DC.dealer_card, (i % 13) + 1);
            @(posedge slow_clock);
            @(negedge slow_clock);
        end

        // Random loads and occasional resets from the free-running generator.
        for (int n = 0; n < 400; n++) begin
            resetb      = ($urandom_range(0, 24) == 0);
            load_pcard1 = ($urandom_range(0, 3) == 0);
            load_pcard2 = ($urandom_range(0, 3) == 0);
            load_pcard3 = ($urandom_range(0, 3) == 0);
            load_dcard1 = ($urandom_range(0, 3) == 0);
            load_dcard2 = ($urandom_range(0, 3) == 0);
            load_dcard3 = ($urandom_range(0, 3) == 0);
            @(posedge slow_clock);
            @(negedge slow_clock);
        end
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = 6'b0;
        resetb = 1'b0;
        @(posedge slow_clock);
        @(negedge slow_clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/baccarat_datapath.md
# baccarat_datapath

Card-holding and scoring datapath of the Baccarat game. It latches up to three player cards and three dealer cards from an internal free-running card generator under load strobes from the game FSM. It computes both hand scores modulo 10, exposes the player's third card for the FSM's drawing rules, and drives six active-low seven-segment displays. Instantiated as `datapath` beneath the top level, beside the controller FSM.

## Interface
- No parameters.
- `slow_clock` input, 1 bit: sole clock; all state updates on its rising edge.
- `resetb` input, 1 bit: synchronous, active-high reset; name kept for codebase consistency.
- `load_pcard1` / `load_pcard2` / `load_pcard3` inputs, 1 bit each: capture the current card into player slot 1/2/3.
- `load_dcard1` / `load_dcard2` / `load_dcard3` inputs, 1 bit each: capture the current card into dealer slot 1/2/3.
- `pcard3_out` output, 4 bits: raw code of player card 3.
- `pscore_out` output, 4 bits: player score, 0–9.
- `dscore_out` output, 4 bits: dealer score, 0–9.
- `HEX0`–`HEX5` outputs, 7 bits each, active-low, bit order {g,f,e,d,c,b,a}:
  - HEX0–HEX2 show player cards 1–3.
  - HEX3–HEX5 show dealer cards 1–3.

## Operation
- Card code, 4 bits:
  - 0 = no card.
  - 1 = Ace; 2–9 face value.
  - 10 = ten; 11 = J; 12 = Q; 13 = K.
  - 14 and 15 are illegal.
- Card generator `dealer_card`: counts 1, 2, …, 13, 1, … advancing once per clock. It resets to 1.
- Six 4-bit card registers, pcard1–3 and dcard1–3.
  - On a clock edge with its load high, a register takes `dealer_card`.
  - Otherwise the register holds its value.
  - Loads are independent. Simultaneous loads all capture the same `dealer_card`.
- Score value of each card: 1–9 map to themselves; 0, 10, J, Q, K, 14 and 15 map to 0.
- `pscore_out` = (v(pcard1) + v(pcard2) + v(pcard3)) mod 10. Compute the sum at 5 bits (max 27) before the modulo. `dscore_out` is computed the same way from the dealer cards.
- Seven-segment decode (active-low):
  - Card codes 0–9: 0 → 1111111 (blank), 1 → 0001000, 2 → 0100100, 3 → 0110000, 4 → 0011001, 5 → 0010010, 6 → 0000010, 7 → 1111000, 8 → 0000000, 9 → 0010000.
  - Card codes 10–15: 10 → 1000000, 11 → 1100001, 12 → 0011000, 13 → 0001001, 14 and 15 → 1111111.
- `pcard3_out` = pcard3 register.

## Timing
- Reset: all six card registers go to 0 and `dealer_card` goes to 1. Outputs then read `pscore_out` = `dscore_out` = 0, `pcard3_out` = 0 and all HEX = 1111111 in the cycle after the reset edge.
- Reset has priority over any load in the same cycle.
- Reset asserted mid-hand discards all cards.
- Load latency: the register updates at the edge that samples the load high. Scores and HEX follow combinationally in the same cycle.
- A load held high for N cycles re-captures every cycle. The last captured value wins.

## Configuration
- `BACCARAT_REG_OUTPUTS_EN`:
  - When defined, `pscore_out`, `dscore_out` and HEX0–5 are registered, adding one cycle of latency after the card register updates. Reset values are unchanged.
  - When undefined (the default), these outputs are purely combinational from the card registers.

## Structure
- Package `baccarat_pkg` holds:
  - Card code constants: CARD_NONE, CARD_ACE, CARD_JACK, CARD_QUEEN, CARD_KING.
  - Seven-segment constants, including SEG_BLANK.
  - A card-to-score function.
  - A card-to-seven-segment function.
- One sub-module, `dealcard`, instantiated as `DC`, with output `dealer_card`. It contains the 1–13 counter. Benches may force `DC.dealer_card`.
- Card registers, scoring and decode live in the top module.

## Test plan
- Hand progression, with `DC.dealer_card` forced before each one-cycle load:
  - Load pcard1 = 2 → pscore 2, dscore 0, HEX0 0100100, rest blank.
  - Load dcard1 = J → HEX3 1100001, dscore 0.
  - Load pcard2 = 8 → pscore 0, HEX1 0000000.
  - Load dcard2 = Q → HEX4 0011000, dscore 0.
  - Load pcard3 = 3 → pscore 3, pcard3_out 3, HEX2 0110000.
  - Load dcard3 = 4 → dscore 4, HEX5 0011001.
- Reset after a full hand → scores 0 and all HEX 1111111 on the next cycle.
- Modulo: player cards 9, 9, 9 → pscore 7. Cards K, 10, A → pscore 1.
- Generator: release the force and hold reset low for 14 cycles → `dealer_card` sequence 1…13, 1.
- Simultaneous `load_pcard1` and `load_dcard1` with card 5 → HEX0 = HEX3 = 0010010, both scores 5.
- Reset and load asserted in the same cycle → register stays 0.
